otter_id_stage: RTL and testbench

Registered instruction-decode stage for the pipelined OTTER RV32I core, placed between the fetch buffer and the execute stage. Each instruction is decoded into the OTTER control bundle and held in an ID/EX output register that uses a valid/ready handshake. The stage also detects load-use hazards and inserts a bubble for them, accepts a flush on redirect, flags illegal encodings, and counts stall cycles.

---
 rtl/otter_pkg.sv | 62 ++++++
 rtl/otter_ctrl_decode.sv | 117 +++++++++++
 rtl/otter_id_stage.sv | 139 +++++++++++++
 tb/tb_otter_id_stage.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// otter_pkg: shared OTTER decode definitions.
// Contents: opcode and funct7 constants, ALU_FUN / SRCA / SRCB / WR_SEL
// encodings, the ctrl_t control bundle and the ID-stage state type.
package otter_pkg;

  localparam int unsigned IR_W   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned ALU_W  = 4;
  localparam int unsigned SRCB_W = 2;
  localparam int unsigned WSEL_W = 2;

  // Major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // R-type funct7 values
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_LUI = 4'b1001;

  localparam logic SRCA_RS1  = 1'b0;
  localparam logic SRCA_UIMM = 1'b1;

  localparam logic [SRCB_W-1:0] SRCB_RS2  = 2'b00;
  localparam logic [SRCB_W-1:0] SRCB_IIMM = 2'b01;
  localparam logic [SRCB_W-1:0] SRCB_SIMM = 2'b10;
  localparam logic [SRCB_W-1:0] SRCB_PC   = 2'b11;

  localparam logic [WSEL_W-1:0] WSEL_PC4 = 2'b00;
  localparam logic [WSEL_W-1:0] WSEL_MEM = 2'b10;
  localparam logic [WSEL_W-1:0] WSEL_ALU = 2'b11;

  typedef struct packed {
    logic [ALU_W-1:0]  alu_fun;
    logic              alu_srca;
    logic [SRCB_W-1:0] alu_srcb;
    logic [WSEL_W-1:0] rf_wr_sel;
    logic              reg_write;
    logic              mem_we2;
    logic              mem_rden2;
    logic              branch;
    logic              jump;
    logic              mdu;
    logic              illegal;
  } ctrl_t;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } id_state_t;

endpackage

// File: rtl/otter_ctrl_decode.sv
// otter_ctrl_decode: combinational RV32I instruction -> ctrl_t decoder.
// Ports: ir (instruction word) in; ctrl (control bundle), rs1/rs2/rd
// (register address fields), rs1_used/rs2_used (operand-use flags) out.
// Macro OTTER_M_EXT_EN: when defined, R-type funct7=0000001 decodes as a
// legal multiply/divide op with mdu=1; otherwise it is illegal.
module otter_ctrl_decode
  import otter_pkg::*;
(
  input  logic [IR_W-1:0]  ir,
  output ctrl_t            ctrl,
  output logic [REG_W-1:0] rs1,
  output logic [REG_W-1:0] rs2,
  output logic [REG_W-1:0] rd,
  output logic             rs1_used,
  output logic             rs2_used
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign rd     = ir[11:7];

  // Opcode decode, then illegal encodings drop all side-effecting flags
  always_comb begin
    ctrl     = '0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (opcode)
      OPC_AUIPC: begin
        ctrl.alu_srca  = SRCA_UIMM;
        ctrl.alu_srcb  = SRCB_PC;
        ctrl.rf_wr_sel = WSEL_ALU;
        ctrl.reg_write = 1'b1;
      end
      OPC_LUI: begin
        ctrl.alu_fun   = ALU_LUI;
        ctrl.alu_srca  = SRCA_UIMM;
        ctrl.rf_wr_sel = WSEL_ALU;
        ctrl.reg_write = 1'b1;
      end
      OPC_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.rf_wr_sel = WSEL_PC4;
        ctrl.reg_write = 1'b1;
      end
      OPC_JALR: begin
        ctrl.jump      = 1'b1;
        ctrl.rf_wr_sel = WSEL_PC4;
        ctrl.reg_write = 1'b1;
        rs1_used       = 1'b1;
      end
      OPC_LOAD: begin
        ctrl.alu_srcb  = SRCB_IIMM;
        ctrl.rf_wr_sel = WSEL_MEM;
        ctrl.reg_write = 1'b1;
        ctrl.mem_rden2 = 1'b1;
        rs1_used       = 1'b1;
      end
      OPC_STORE: begin
        ctrl.alu_srcb = SRCB_SIMM;
        ctrl.mem_we2  = 1'b1;
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl.alu_srcb  = SRCB_IIMM;
        ctrl.rf_wr_sel = WSEL_ALU;
        ctrl.reg_write = 1'b1;
        // Only the shift-right pair needs IR[30] to pick SRL vs SRA
        ctrl.alu_fun   = (funct3 == 3'b101) ? {ir[30], funct3} : {1'b0, funct3};
        rs1_used       = 1'b1;
      end
      OPC_OP: begin
        ctrl.rf_wr_sel = WSEL_ALU;
        ctrl.reg_write = 1'b1;
        ctrl.alu_fun   = {ir[30], funct3};
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
        ctrl.illegal   = 1'b1;
        if (funct7 == F7_BASE || funct7 == F7_ALT) begin
          ctrl.illegal = 1'b0;
        end
`ifdef OTTER_M_EXT_EN
        if (funct7 == F7_MULDIV) begin
          ctrl.illegal = 1'b0;
          ctrl.mdu     = 1'b1;
          ctrl.alu_fun = {1'b0, funct3};
        end
`endif
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase

    if (ctrl.illegal) begin
      ctrl.reg_write = 1'b0;
      ctrl.mem_we2   = 1'b0;
      ctrl.mem_rden2 = 1'b0;
      ctrl.branch    = 1'b0;
      ctrl.jump      = 1'b0;
      ctrl.mdu       = 1'b0;
    end
  end

endmodule

// File: rtl/otter_id_stage.sv
// otter_id_stage: registered instruction-decode stage (ID/EX register).
// Ports: clk, rst_n (async active-low); fetch side if_valid/if_ready/
// if_ir/if_pc; flush (redirect); execute side ex_ready/ex_valid and the
// registered ex_* fields; stall_cnt (saturating load-use bubble count).
// Macro OTTER_M_EXT_EN: enables legal decode of RV32M (ex_mdu); without it
// ex_mdu is always 0.
module otter_id_stage
  import otter_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [IR_W-1:0]   if_ir,
  input  logic [XLEN-1:0]   if_pc,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [IR_W-1:0]   ex_ir,
  output logic [REG_W-1:0]  ex_rs1,
  output logic [REG_W-1:0]  ex_rs2,
  output logic [REG_W-1:0]  ex_rd,
  output logic [ALU_W-1:0]  ex_alu_fun,
  output logic              ex_alu_srca,
  output logic [SRCB_W-1:0] ex_alu_srcb,
  output logic [WSEL_W-1:0] ex_rf_wr_sel,
  output logic              ex_reg_write,
  output logic              ex_mem_we2,
  output logic              ex_mem_rden2,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic              ex_mdu,
  output logic              ex_illegal,
  output logic [CNT_W-1:0]  stall_cnt
);

  ctrl_t            dec_ctrl;
  logic [REG_W-1:0] dec_rs1;
  logic [REG_W-1:0] dec_rs2;
  logic [REG_W-1:0] dec_rd;
  logic             rs1_used;
  logic             rs2_used;

  id_state_t state;
  ctrl_t     ex_ctrl;

  logic load_in_ex;
  logic hazard;
  logic accept;
  logic load;
  logic clear;

  otter_ctrl_decode u_decode (
    .ir       (if_ir),
    .ctrl     (dec_ctrl),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .rd       (dec_rd),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );

  assign ex_valid = (state == S_FULL);

  // Load leaving EX this cycle whose result the incoming instruction needs
  assign load_in_ex = ex_valid & ex_ready & ex_ctrl.mem_rden2 & (ex_rd != '0);
  assign hazard     = if_valid & load_in_ex &
                      ((rs1_used & (dec_rs1 == ex_rd)) | (rs2_used & (dec_rs2 == ex_rd)));

  // Gated by rst_n so fetch sees no acceptance while in reset
  assign if_ready = rst_n & ~flush & ~hazard & (~ex_valid | ex_ready);
  assign accept   = if_valid & if_ready;

  // Register action: flush/bubble clear, accept loads, stalled FULL holds
  always_comb begin
    load  = 1'b0;
    clear = 1'b0;
    if (flush || hazard) begin
      clear = 1'b1;
    end else if (accept) begin
      load = 1'b1;
    end else if (!ex_valid || ex_ready) begin
      clear = 1'b1;
    end
  end

  // ID/EX register, occupancy state and stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_EMPTY;
      ex_pc     <= '0;
      ex_ir     <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_ctrl   <= '0;
      stall_cnt <= '0;
    end else begin
      if (clear) begin
        state   <= S_EMPTY;
        ex_pc   <= '0;
        ex_ir   <= '0;
        ex_rs1  <= '0;
        ex_rs2  <= '0;
        ex_rd   <= '0;
        ex_ctrl <= '0;
      end else if (load) begin
        state   <= S_FULL;
        ex_pc   <= if_pc;
        ex_ir   <= if_ir;
        ex_rs1  <= dec_rs1;
        ex_rs2  <= dec_rs2;
        ex_rd   <= dec_rd;
        ex_ctrl <= dec_ctrl;
      end
      // A flush overrides the hazard, so that bubble is not counted
      if (hazard && !flush && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  assign ex_alu_fun   = ex_ctrl.alu_fun;
  assign ex_alu_srca  = ex_ctrl.alu_srca;
  assign ex_alu_srcb  = ex_ctrl.alu_srcb;
  assign ex_rf_wr_sel = ex_ctrl.rf_wr_sel;
  assign ex_reg_write = ex_ctrl.reg_write;
  assign ex_mem_we2   = ex_ctrl.mem_we2;
  assign ex_mem_rden2 = ex_ctrl.mem_rden2;
  assign ex_branch    = ex_ctrl.branch;
  assign ex_jump      = ex_ctrl.jump;
  assign ex_mdu       = ex_ctrl.mdu;
  assign ex_illegal   = ex_ctrl.illegal;

endmodule

// File: tb/tb_otter_id_stage.sv
// tb_otter_id_stage: scoreboard bench for otter_id_stage.
// Accepted instructions push their expected decode into a queue; a monitor
// pops and compares each one as EX consumes it.
module tb_otter_id_stage;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_ir;
  logic [31:0] if_pc;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_ir;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_fun;
  logic        ex_alu_srca;
  logic [1:0]  ex_alu_srcb;
  logic [1:0]  ex_rf_wr_sel;
  logic        ex_reg_write, ex_mem_we2, ex_mem_rden2, ex_branch, ex_jump;
  logic        ex_mdu, ex_illegal;
  logic [15:0] stall_cnt;

  otter_id_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
    .if_ir(if_ir), .if_pc(if_pc), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_ir(ex_ir), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_fun(ex_alu_fun),
    .ex_alu_srca(ex_alu_srca), .ex_alu_srcb(ex_alu_srcb),
    .ex_rf_wr_sel(ex_rf_wr_sel), .ex_reg_write(ex_reg_write),
    .ex_mem_we2(ex_mem_we2), .ex_mem_rden2(ex_mem_rden2),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_mdu(ex_mdu),
    .ex_illegal(ex_illegal), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu_fun;
    logic        srca;
    logic [1:0]  srcb, wr_sel;
    logic        reg_write, we2, rden2, branch, jump, mdu, illegal;
  } rec_t;

  int   tests = 0;
  int   fails = 0;
  rec_t exp_q[$];

  // Reference model of the stage: occupancy plus what matters for hazards
  logic        m_valid = 1'b0;
  logic        m_load  = 1'b0;
  logic [4:0]  m_rd    = '0;
  logic [15:0] m_cnt   = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Decode written straight from the instruction-class rules
  function automatic rec_t ref_decode(input logic [31:0] ir, input logic [31:0] pc);
    rec_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    e = '0;
    f3 = ir[14:12];
    f7 = ir[31:25];
    e.pc = pc; e.ir = ir;
    e.rs1 = ir[19:15]; e.rs2 = ir[24:20]; e.rd = ir[11:7];
    case (ir[6:0])
      7'b0010111: begin e.srca = 1; e.srcb = 2'b11; e.wr_sel = 2'b11; e.reg_write = 1; end
      7'b0110111: begin e.alu_fun = 4'b1001; e.srca = 1; e.wr_sel = 2'b11; e.reg_write = 1; end
      7'b1101111, 7'b1100111: begin e.jump = 1; e.wr_sel = 2'b00; e.reg_write = 1; end
      7'b0000011: begin e.srcb = 2'b01; e.wr_sel = 2'b10; e.reg_write = 1; e.rden2 = 1; end
      7'b0100011: begin e.srcb = 2'b10; e.we2 = 1; end
      7'b0010011: begin
        e.srcb = 2'b01; e.wr_sel = 2'b11; e.reg_write = 1;
        e.alu_fun = (f3 == 3'd5) ? {ir[30], 3'b101} : {1'b0, f3};
      end
      7'b0110011: begin
        e.wr_sel = 2'b11; e.reg_write = 1; e.alu_fun = {ir[30], f3};
        if (f7 == 7'h00 || f7 == 7'h20) e.illegal = 0;
`ifdef OTTER_M_EXT_EN
        else if (f7 == 7'h01) begin e.mdu = 1; e.alu_fun = {1'b0, f3}; end
`endif
        else e.illegal = 1;
      end
      7'b1100011: e.branch = 1;
      default: e.illegal = 1;
    endcase
    if (e.illegal) begin
      e.reg_write = 0; e.we2 = 0; e.rden2 = 0; e.branch = 0; e.jump = 0; e.mdu = 0;
    end
    return e;
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
           op == 7'b0100011 || op == 7'b1100011 || op == 7'b1100111;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
  endfunction

  function automatic rec_t dut_rec();
    rec_t a;
    a = '{ex_pc, ex_ir, ex_rs1, ex_rs2, ex_rd, ex_alu_fun, ex_alu_srca, ex_alu_srcb,
          ex_rf_wr_sel, ex_reg_write, ex_mem_we2, ex_mem_rden2, ex_branch, ex_jump,
          ex_mdu, ex_illegal};
    return a;
  endfunction

  // One clock cycle of stimulus; model advances at the rising edge
  task automatic step(input logic v, input logic [31:0] ir, input logic [31:0] pc,
                      input logic rdy, input logic fl, output logic acc);
    rec_t e;
    logic hz, ird;
    if_valid = v; if_ir = ir; if_pc = pc; ex_ready = rdy; flush = fl;
    e = ref_decode(ir, pc);
    @(negedge clk);
    hz  = m_valid && rdy && m_load && (m_rd != 0) && v &&
          ((uses_rs1(ir[6:0]) && ir[19:15] == m_rd) || (uses_rs2(ir[6:0]) && ir[24:20] == m_rd));
    ird = !fl && !hz && (!m_valid || rdy);
    chk("if_ready", 128'(if_ready), 128'(ird));
    chk("ex_valid", 128'(ex_valid), 128'(m_valid));
    chk("stall_cnt", 128'(stall_cnt), 128'(m_cnt));
    acc = v && ird;
    @(posedge clk);
    if (fl) m_valid = 0;
    else if (hz) begin
      m_valid = 0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (acc) begin
      m_valid = 1; m_rd = ir[11:7]; m_load = (ir[6:0] == 7'b0000011);
      exp_q.push_back(e);
    end else if (!(m_valid && !rdy)) m_valid = 0;
    #1;
  endtask

  task automatic send(input logic [31:0] ir, input logic [31:0] pc);
    logic acc;
    acc = 0;
    for (int i = 0; i < 8 && !acc; i++) step(1'b1, ir, pc, 1'b1, 1'b0, acc);
    if (!acc) begin
      tests++; fails++;
      $display("FAIL send_timeout: ir 0x%08h not accepted within 8 cycles", ir);
    end
  endtask

  task automatic mid_reset();
    #1 rst_n = 0;
    #1;
    chk("reset_async_outputs",
        128'({ex_valid, if_ready, ex_pc, ex_ir, ex_rs1, ex_rs2, ex_rd, ex_alu_fun,
              ex_alu_srca, ex_alu_srcb, ex_rf_wr_sel, ex_reg_write, ex_mem_we2,
              ex_mem_rden2, ex_branch, ex_jump, ex_mdu, ex_illegal, stall_cnt}), 128'(0));
    exp_q.delete();
    m_valid = 0; m_cnt = 0; m_load = 0; m_rd = 0;
    if_valid = 0; flush = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 11);
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    w[11:7]  = 5'($urandom_range(0, 3));
    case (k)
      0: w[6:0] = 7'b0110111;
      1: w[6:0] = 7'b0010111;
      2: w[6:0] = 7'b1101111;
      3: w[6:0] = 7'b1100111;
      4: w[6:0] = 7'b1100011;
      5, 6: w[6:0] = 7'b0000011;
      7: w[6:0] = 7'b0100011;
      8: w[6:0] = 7'b0010011;
      9, 10: begin
        w[6:0] = 7'b0110011;
        case ($urandom_range(0, 3))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          2: w[31:25] = 7'h01;
          default: ;
        endcase
      end
      default: ;
    endcase
    return w;
  endfunction

  // Monitor: compare each consumed instruction and check stability while stalled
  initial begin
    rec_t act, snap, e;
    logic prev_hold;
    prev_hold = 0;
    snap = '0;
    forever begin
      @(negedge clk);
      act = dut_rec();
      if (!rst_n) prev_hold = 0;
      else begin
        if (prev_hold && ex_valid) chk("hold_stable", 128'(act), 128'(snap));
        if (ex_valid && ex_ready) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_output: ir 0x%08h with empty scoreboard", ex_ir);
          end else begin
            e = exp_q.pop_front();
            chk("ex_record", 128'(act), 128'(e));
          end
        end
        prev_hold = ex_valid && !ex_ready;
        snap = act;
      end
    end
  end

  initial begin
    logic acc;
    logic [15:0] saved_cnt;
    logic [31:0] pc;
    rst_n = 0; if_valid = 0; if_ir = '0; if_pc = '0; flush = 0; ex_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ex_valid", 128'(ex_valid), 128'(0));
    chk("reset_if_ready", 128'(if_ready), 128'(0));
    chk("reset_stall_cnt", 128'(stall_cnt), 128'(0));
    #2 rst_n = 1;

    // addi x1,x0,5
    send(32'h00500093, 32'h0);
    chk("addi_valid", 128'(ex_valid), 128'(1));
    chk("addi_rd", 128'(ex_rd), 128'(1));
    chk("addi_srcb", 128'(ex_alu_srcb), 128'(2'b01));
    chk("addi_wrsel", 128'(ex_rf_wr_sel), 128'(2'b11));
    chk("addi_regwrite", 128'(ex_reg_write), 128'(1));
    chk("addi_alufun", 128'(ex_alu_fun), 128'(0));

    // lw x2,0(x1) then add x3,x2,x1: one bubble
    send(32'h0000A103, 32'h4);
    step(1'b1, 32'h001101B3, 32'h8, 1'b1, 1'b0, acc);
    chk("loaduse_not_accepted", 128'(acc), 128'(0));
    chk("loaduse_bubble", 128'(ex_valid), 128'(0));
    chk("loaduse_stall_cnt", 128'(stall_cnt), 128'(1));
    send(32'h001101B3, 32'h8);
    chk("add_after_bubble", 128'({ex_valid, ex_ir}), 128'({1'b1, 32'h001101B3}));
    chk("add_alufun", 128'(ex_alu_fun), 128'(0));

    // Hold with EX_READY low for three cycles
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h00700213, 32'hC, 1'b0, 1'b0, acc);
      chk("hold_ir", 128'(ex_ir), 128'(32'h001101B3));
    end
    send(32'h00700213, 32'hC);
    chk("after_hold_load", 128'(ex_ir), 128'(32'h00700213));

    // Flush coincident with a load-use hazard
    send(32'h0000A103, 32'h10);
    saved_cnt = stall_cnt;
    step(1'b1, 32'h001101B3, 32'h14, 1'b1, 1'b1, acc);
    chk("flush_valid", 128'(ex_valid), 128'(0));
    chk("flush_stall_cnt", 128'(stall_cnt), 128'(saved_cnt));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    chk("flush_dropped", 128'(ex_valid), 128'(0));

    // mul x3,x1,x2
    send(32'h022081B3, 32'h18);
`ifdef OTTER_M_EXT_EN
    chk("mul_mdu", 128'({ex_mdu, ex_reg_write, ex_illegal}), 128'(3'b110));
`else
    chk("mul_illegal", 128'({ex_mdu, ex_reg_write, ex_illegal}), 128'(3'b001));
`endif

    // beq x1,x2,+8
    send(32'h00208463, 32'h1C);
    chk("beq_flags", 128'({ex_branch, ex_reg_write}), 128'(2'b10));

    // Randomized streaming with a mid-stream reset
    pc = 32'h100;
    for (int n = 0; n < 1500; n++) begin
      logic v, rdy, fl;
      v   = ($urandom_range(0, 4) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      fl  = rdy && ($urandom_range(0, 15) == 0);
      step(v, rand_ir(), pc, rdy, fl, acc);
      if (acc) pc = pc + 32'd4;
      if (n == 700) mid_reset();
    end

    // Drain
    for (int i = 0; i < 10 && (exp_q.size() != 0 || m_valid); i++)
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
